// File: rtl/debug_pll_reset_seq_if.sv
// Signal bundle between the debug PLL reset sequencer and the PLL wrapper / downstream logic.
// DEBUG_PLL_SEQ_STATUS_EN adds the loss_cnt / retry_cnt status counters.
interface debug_pll_reset_seq_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       lock_fail;
    logic [2:0] state_o;
`ifdef DEBUG_PLL_SEQ_STATUS_EN
    logic [7:0] loss_cnt;
    logic [7:0] retry_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst_n, pll_ready, lock_fail, state_o, loss_cnt, retry_cnt
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst_n, pll_ready, lock_fail, state_o, loss_cnt, retry_cnt
    );
`else
    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst_n, pll_ready, lock_fail, state_o
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst_n, pll_ready, lock_fail, state_o
    );
`endif
endinterface

// File: rtl/debug_pll_reset_seq.sv
// Power-up / relock sequencer for the debug PLL: reset hold, lock wait with retry, stability
// qualification, then downstream reset release. DEBUG_PLL_SEQ_STATUS_EN adds status counters.
module debug_pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    debug_pll_reset_seq_if.master seq
);
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_TERM   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_TERM   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_WAIT = 3'd1,
        ST_STAB = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       retries_reg, retries_next;
    logic [7:0]       retry_inc;
    logic             lk_meta_reg, lk_s_reg;
    logic             pll_rst_reg, pll_rst_next;
    logic             sys_rst_n_reg, sys_rst_n_next;
    logic             pll_ready_reg, pll_ready_next;
    logic             lock_fail_reg, lock_fail_next;
    logic             timeout_evt, loss_evt;

    // pll_locked is asynchronous to refclk; only the synchronized copy is used.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_reg <= 1'b0;
            lk_s_reg    <= 1'b0;
        end else begin
            lk_meta_reg <= seq.pll_locked;
            lk_s_reg    <= lk_meta_reg;
        end
    end

    assign retry_inc = retries_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        retries_next = retries_reg;
        timeout_evt  = 1'b0;
        loss_evt     = 1'b0;

        case (state_reg)
            ST_HOLD: begin
                if (cnt_reg >= HOLD_TERM) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (lk_s_reg) begin
                    state_next = ST_STAB;
                    cnt_next   = '0;
                end else if (cnt_reg >= WAIT_TERM) begin
                    timeout_evt  = 1'b1;
                    retries_next = retry_inc;
                    state_next   = (retry_inc >= RETRY_LIMIT) ? ST_FAIL : ST_HOLD;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STAB: begin
                // A lock glitch during qualification is not a failed attempt.
                if (!lk_s_reg) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else if (cnt_reg >= STAB_TERM) begin
                    state_next   = ST_RUN;
                    cnt_next     = '0;
                    retries_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (!lk_s_reg) begin
                    state_next = ST_HOLD;
                    loss_evt   = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
            end
        endcase

        // A relock request pre-empts whatever transition was about to happen this cycle.
        if (seq.relock_req) begin
            state_next   = ST_HOLD;
            cnt_next     = '0;
            timeout_evt  = 1'b0;
            loss_evt     = 1'b0;
            retries_next = (state_reg == ST_FAIL) ? 8'd0 : retries_reg;
        end
    end

    // Outputs are registered from the next state so they change together with state_o.
    always_comb begin
        pll_rst_next   = (state_next == ST_HOLD) || (state_next == ST_FAIL);
        sys_rst_n_next = (state_next == ST_RUN);
        pll_ready_next = (state_next == ST_RUN);
        lock_fail_next = (state_next == ST_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_HOLD;
            cnt_reg       <= '0;
            retries_reg   <= '0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            pll_ready_reg <= 1'b0;
            lock_fail_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retries_reg   <= retries_next;
            pll_rst_reg   <= pll_rst_next;
            sys_rst_n_reg <= sys_rst_n_next;
            pll_ready_reg <= pll_ready_next;
            lock_fail_reg <= lock_fail_next;
        end
    end

    assign seq.pll_rst   = pll_rst_reg;
    assign seq.sys_rst_n = sys_rst_n_reg;
    assign seq.pll_ready = pll_ready_reg;
    assign seq.lock_fail = lock_fail_reg;
    assign seq.state_o   = state_reg;

`ifdef DEBUG_PLL_SEQ_STATUS_EN
    logic [7:0] loss_cnt_reg, loss_cnt_next;
    logic [7:0] retry_cnt_reg, retry_cnt_next;

    // Both counters survive relock_req and stick at 255.
    always_comb begin
        loss_cnt_next  = loss_cnt_reg;
        retry_cnt_next = retry_cnt_reg;
        if (loss_evt && (loss_cnt_reg != 8'hFF)) begin
            loss_cnt_next = loss_cnt_reg + 8'd1;
        end
        if (timeout_evt && (retry_cnt_reg != 8'hFF)) begin
            retry_cnt_next = retry_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg  <= 8'd0;
            retry_cnt_reg <= 8'd0;
        end else begin
            loss_cnt_reg  <= loss_cnt_next;
            retry_cnt_reg <= retry_cnt_next;
        end
    end

    assign seq.loss_cnt  = loss_cnt_reg;
    assign seq.retry_cnt = retry_cnt_reg;
`endif

endmodule

// File: tb/tb_debug_pll_reset_seq.sv
// Directed bench for debug_pll_reset_seq with RST=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=3.
// Status-counter checks are compiled in only with DEBUG_PLL_SEQ_STATUS_EN.
module tb_debug_pll_reset_seq;
    logic refclk = 1'b0;
    logic rst_n  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    debug_pll_reset_seq_if bus ();

    debug_pll_reset_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .seq   (bus)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s got=%0h t=%0t", tag, got, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.state_o == code) break;
        end
        check(tag, {29'd0, bus.state_o}, {29'd0, code});
    endtask

    task automatic pulse_relock();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_pll_rst",   {31'd0, bus.pll_rst},   32'd1);
        check("rst_sys_rst_n", {31'd0, bus.sys_rst_n}, 32'd0);
        check("rst_pll_ready", {31'd0, bus.pll_ready}, 32'd0);
        check("rst_lock_fail", {31'd0, bus.lock_fail}, 32'd0);
        check("rst_state",     {29'd0, bus.state_o},   32'd0);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("rst_loss_cnt",  {24'd0, bus.loss_cnt},  32'd0);
        check("rst_retry_cnt", {24'd0, bus.retry_cnt}, 32'd0);
`endif
        #3 rst_n = 1'b1;

        // 1: HOLD for 4 cycles, WAIT, lock seen after sync, 8 stable cycles, RUN
        tick(3);
        check("t1_hold_state",   {29'd0, bus.state_o}, 32'd0);
        check("t1_hold_pll_rst", {31'd0, bus.pll_rst}, 32'd1);
        tick();
        check("t1_wait_state",   {29'd0, bus.state_o}, 32'd1);
        check("t1_wait_pll_rst", {31'd0, bus.pll_rst}, 32'd0);
        bus.pll_locked = 1'b1;
        tick(2);
        check("t1_sync_lat", {29'd0, bus.state_o}, 32'd1);
        tick();
        check("t1_stab_entry", {29'd0, bus.state_o}, 32'd2);
        tick(7);
        check("t1_stab_7",      {29'd0, bus.state_o},   32'd2);
        check("t1_stab_sysrst", {31'd0, bus.sys_rst_n}, 32'd0);
        check("t1_stab_ready",  {31'd0, bus.pll_ready}, 32'd0);
        tick();
        check("t1_run_state",   {29'd0, bus.state_o},   32'd3);
        check("t1_run_sysrst",  {31'd0, bus.sys_rst_n}, 32'd1);
        check("t1_run_ready",   {31'd0, bus.pll_ready}, 32'd1);
        check("t1_run_pll_rst", {31'd0, bus.pll_rst},   32'd0);

        // 4: lock loss in RUN
        bus.pll_locked = 1'b0;
        tick(2);
        check("t4_still_run", {29'd0, bus.state_o},   32'd3);
        check("t4_still_rel", {31'd0, bus.sys_rst_n}, 32'd1);
        tick();
        check("t4_hold_state",  {29'd0, bus.state_o},   32'd0);
        check("t4_sysrst",      {31'd0, bus.sys_rst_n}, 32'd0);
        check("t4_ready",       {31'd0, bus.pll_ready}, 32'd0);
        check("t4_pll_rst",     {31'd0, bus.pll_rst},   32'd1);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("t4_loss_cnt",    {24'd0, bus.loss_cnt},  32'd1);
`endif

        // 3: one-cycle lock drop at stable count 5
        bus.pll_locked = 1'b1;
        wait_state(3'd2, 20, "t3_reach_stab");
        tick(5);
        check("t3_cnt5", {29'd0, bus.state_o}, 32'd2);
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        tick();
        check("t3_pre_drop",  {29'd0, bus.state_o}, 32'd2);
        tick();
        check("t3_back_wait", {29'd0, bus.state_o}, 32'd1);
        tick();
        check("t3_restab",    {29'd0, bus.state_o}, 32'd2);
        tick(7);
        check("t3_fresh_7",   {29'd0, bus.state_o},   32'd2);
        check("t3_sysrst_lo", {31'd0, bus.sys_rst_n}, 32'd0);
        tick();
        check("t3_run",       {29'd0, bus.state_o},   32'd3);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("t3_no_retry",  {24'd0, bus.retry_cnt}, 32'd0);
`endif

        // 5: relock_req from RUN, then colliding with STAB terminal count
        pulse_relock();
        check("t5_run_relock", {29'd0, bus.state_o},   32'd0);
        check("t5_run_sysrst", {31'd0, bus.sys_rst_n}, 32'd0);
        wait_state(3'd2, 20, "t5_reach_stab");
        tick(7);
        check("t5_stab_7", {29'd0, bus.state_o}, 32'd2);
        pulse_relock();
        check("t5_hold",    {29'd0, bus.state_o},   32'd0);
        check("t5_sysrst",  {31'd0, bus.sys_rst_n}, 32'd0);
        check("t5_ready",   {31'd0, bus.pll_ready}, 32'd0);
        check("t5_pll_rst", {31'd0, bus.pll_rst},   32'd1);
        tick();
        check("t5_stay_rst", {31'd0, bus.sys_rst_n}, 32'd0);

        // 2: no lock -> three timeouts -> FAIL, then relock
        bus.pll_locked = 1'b0;
        wait_state(3'd1, 20, "t2_reach_wait");
        tick(19);
        check("t2_wait19_a", {29'd0, bus.state_o}, 32'd1);
        tick();
        check("t2_to1_hold", {29'd0, bus.state_o}, 32'd0);
        check("t2_to1_prst", {31'd0, bus.pll_rst}, 32'd1);
        tick(3);
        check("t2_hold3",    {29'd0, bus.state_o}, 32'd0);
        tick();
        check("t2_wait_b",   {29'd0, bus.state_o}, 32'd1);
        tick(19);
        check("t2_wait19_b", {29'd0, bus.state_o}, 32'd1);
        tick();
        check("t2_to2_hold", {29'd0, bus.state_o}, 32'd0);
        tick(4);
        check("t2_wait_c",   {29'd0, bus.state_o}, 32'd1);
        tick(19);
        check("t2_wait19_c", {29'd0, bus.state_o}, 32'd1);
        tick();
        check("t2_fail_state", {29'd0, bus.state_o},   32'd4);
        check("t2_lock_fail",  {31'd0, bus.lock_fail}, 32'd1);
        check("t2_fail_prst",  {31'd0, bus.pll_rst},   32'd1);
        check("t2_fail_sys",   {31'd0, bus.sys_rst_n}, 32'd0);
        tick(5);
        check("t2_fail_stay",  {29'd0, bus.state_o},   32'd4);
        check("t2_fail_stick", {31'd0, bus.lock_fail}, 32'd1);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("t2_retry_cnt",  {24'd0, bus.retry_cnt}, 32'd3);
`endif
        pulse_relock();
        check("t2_relock_state", {29'd0, bus.state_o},   32'd0);
        check("t2_relock_lf",    {31'd0, bus.lock_fail}, 32'd0);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("t2_retry_kept",   {24'd0, bus.retry_cnt}, 32'd3);
`endif
        tick(3);
        check("t2_rl_hold3", {29'd0, bus.state_o}, 32'd0);
        tick();
        check("t2_rl_wait",  {29'd0, bus.state_o}, 32'd1);
        tick(20);
        check("t2_retry_cleared", {29'd0, bus.state_o}, 32'd0);

        // 6: async reset in the middle of WAIT
        wait_state(3'd1, 10, "t6_reach_wait");
        tick(5);
        check("t6_mid_wait", {29'd0, bus.state_o}, 32'd1);
        check("t6_prst_lo",  {31'd0, bus.pll_rst}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_async_state", {29'd0, bus.state_o},   32'd0);
        check("t6_async_prst",  {31'd0, bus.pll_rst},   32'd1);
        check("t6_async_sys",   {31'd0, bus.sys_rst_n}, 32'd0);
        check("t6_async_ready", {31'd0, bus.pll_ready}, 32'd0);
        check("t6_async_lf",    {31'd0, bus.lock_fail}, 32'd0);
`ifdef DEBUG_PLL_SEQ_STATUS_EN
        check("t6_async_retry", {24'd0, bus.retry_cnt}, 32'd0);
        check("t6_async_loss",  {24'd0, bus.loss_cnt},  32'd0);
`endif
        #2 rst_n = 1'b1;
        tick(3);
        check("t6_restart_hold", {29'd0, bus.state_o}, 32'd0);
        check("t6_restart_prst", {31'd0, bus.pll_rst}, 32'd1);
        tick();
        check("t6_restart_wait", {29'd0, bus.state_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
